// File: rtl/display_source_mux.sv
// Registered selector routing one of NUM_SRC hex-digit sources to the seven-segment decoders,
// with manual, auto-rotate, blink and hold modes plus a source-change strobe.
module display_source_mux #(
    parameter int unsigned NUM_SRC      = 3,
    parameter int unsigned DIGITS       = 3,
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned BLINK_HALF   = 12500000,
    parameter int unsigned SEL_W        = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*DIGITS*4-1:0] src_flat,
    input  logic [SEL_W-1:0]            sel,
    input  logic [1:0]                  mode,
    output logic [DIGITS*4-1:0]         digits_out,
    output logic                        blank_out,
    output logic [SEL_W-1:0]            cur_src,
    output logic                        switched
);

    localparam int unsigned DW_W = $clog2(DWELL_CYCLES);
    localparam int unsigned BL_W = $clog2(BLINK_HALF + 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [BL_W-1:0]  BLINK_LAST = BL_W'(BLINK_HALF - 1);
    localparam logic [SEL_W-1:0] LAST_SRC   = SEL_W'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        StManual = 2'b00,
        StAuto   = 2'b01,
        StBlink  = 2'b10,
        StHold   = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    cur_q, cur_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [BL_W-1:0]     blink_q, blink_d;
    logic                blank_q, blank_d;
    logic                switched_q, switched_d;
    logic [DIGITS*4-1:0] digits_q, digits_d;
    logic [DIGITS*4-1:0] slice;
    logic                entering;

    always_comb begin
        state_d    = state_e'(mode);
        entering   = (state_d != state_q);
        cur_d      = cur_q;
        dwell_d    = '0;
        blink_d    = '0;
        blank_d    = 1'b0;
        digits_d   = digits_q;
        slice      = '0;

        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (cur_q == SEL_W'(s)) begin
                slice = src_flat[s*DIGITS*4 +: DIGITS*4];
            end
        end

        case (state_d)
            StManual: begin
                if (sel <= LAST_SRC) cur_d = sel;
            end
            StAuto: begin
                // A mode change on the terminal cycle restarts the dwell instead of advancing.
                if (!entering) begin
                    if (dwell_q == DWELL_LAST) begin
                        cur_d = (cur_q == LAST_SRC) ? '0 : cur_q + 1'b1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            StBlink: begin
                if (sel <= LAST_SRC) cur_d = sel;
                if (!entering) begin
                    blank_d = blank_q;
                    if (blink_q == BLINK_LAST) begin
                        blank_d = ~blank_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (state_d != StHold) digits_d = slice;
        switched_d = (cur_d != cur_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StManual;
            cur_q      <= '0;
            dwell_q    <= '0;
            blink_q    <= '0;
            blank_q    <= 1'b0;
            switched_q <= 1'b0;
            digits_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            dwell_q    <= dwell_d;
            blink_q    <= blink_d;
            blank_q    <= blank_d;
            switched_q <= switched_d;
            digits_q   <= digits_d;
        end
    end

    assign digits_out = digits_q;
    assign blank_out  = blank_q;
    assign cur_src    = cur_q;
    assign switched   = switched_q;

endmodule

// File: tb/tb_display_source_mux.sv
// Bench for display_source_mux: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a time-since-entry behavioural model.
module tb_display_source_mux;

    localparam int NUM_SRC    = 3;
    localparam int DIGITS     = 3;
    localparam int DWELL      = 4;
    localparam int BLINK_HALF = 2;
    localparam int SEL_W      = 2;
    localparam int DW         = DIGITS * 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_SRC*DW-1:0]     src_flat;
    logic [SEL_W-1:0]          sel;
    logic [1:0]                mode;
    logic [DW-1:0]             digits_out;
    logic                      blank_out;
    logic [SEL_W-1:0]          cur_src;
    logic                      switched;

    int checks = 0;
    int errors = 0;

    display_source_mux #(
        .NUM_SRC      (NUM_SRC),
        .DIGITS       (DIGITS),
        .DWELL_CYCLES (DWELL),
        .BLINK_HALF   (BLINK_HALF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_flat   (src_flat),
        .sel        (sel),
        .mode       (mode),
        .digits_out (digits_out),
        .blank_out  (blank_out),
        .cur_src    (cur_src),
        .switched   (switched)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t counts clocks since the mode was entered; rotation and blink phase derive from it.
    int            m_cur   = 0;
    int            m_t     = 0;
    int            m_prev  = 0;
    logic [DW-1:0] m_dig   = '0;
    logic          m_blank = 1'b0;
    logic          m_sw    = 1'b0;

    always @(posedge clk or posedge reset) begin
        int t_n;
        int c_n;
        if (reset) begin
            m_cur   <= 0;
            m_t     <= 0;
            m_prev  <= 0;
            m_dig   <= '0;
            m_blank <= 1'b0;
            m_sw    <= 1'b0;
        end else begin
            t_n = (int'(mode) != m_prev) ? 0 : m_t + 1;
            c_n = m_cur;
            if ((mode == 2'd0 || mode == 2'd2) && int'(sel) < NUM_SRC) c_n = int'(sel);
            if (mode == 2'd1 && t_n > 0 && (t_n % DWELL) == 0) c_n = (m_cur + 1) % NUM_SRC;
            m_t     <= t_n;
            m_prev  <= int'(mode);
            m_cur   <= c_n;
            m_blank <= (mode == 2'd2) && (((t_n / BLINK_HALF) % 2) == 1);
            if (mode != 2'd3) m_dig <= src_flat[m_cur*DW +: DW];
            m_sw    <= (c_n != m_cur);
        end
    end

    always @(negedge clk) begin
        chk("model_cur_src", 32'(cur_src), 32'(m_cur));
        chk("model_digits", 32'(digits_out), 32'(m_dig));
        chk("model_blank", 32'(blank_out), 32'(m_blank));
        chk("model_switched", 32'(switched), 32'(m_sw));
    end

    bit exp_blink [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        reset    = 1'b1;
        mode     = 2'd0;
        sel      = '0;
        src_flat = '0;
        src_flat[0  +: DW] = 12'h123;
        src_flat[DW +: DW] = 12'hABC;
        src_flat[2*DW +: DW] = 12'hDEF;
        #3;
        chk("reset_digits", 32'(digits_out), 32'h0);
        chk("reset_cur", 32'(cur_src), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("manual_src0", 32'(digits_out), 32'h123);

        sel = 2'd1;
        @(negedge clk);
        chk("sel1_cur", 32'(cur_src), 32'h1);
        chk("sel1_strobe", 32'(switched), 32'h1);
        @(negedge clk);
        chk("sel1_strobe_end", 32'(switched), 32'h0);
        chk("sel1_digits", 32'(digits_out), 32'hABC);

        sel = 2'd3;
        repeat (2) @(negedge clk);
        chk("sel_oob_cur", 32'(cur_src), 32'h1);
        chk("sel_oob_strobe", 32'(switched), 32'h0);

        sel = 2'd2;
        repeat (2) @(negedge clk);
        mode = 2'd1;
        repeat (4) @(negedge clk);
        chk("auto_dwell", 32'(cur_src), 32'h2);
        @(negedge clk);
        chk("auto_wrap", 32'(cur_src), 32'h0);
        chk("auto_strobe", 32'(switched), 32'h1);
        repeat (3) @(negedge clk);
        chk("auto_hold0", 32'(cur_src), 32'h0);
        @(negedge clk);
        chk("auto_adv1", 32'(cur_src), 32'h1);

        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_cur", 32'(cur_src), 32'h0);
        chk("async_rst_digits", 32'(digits_out), 32'h0);
        chk("async_rst_blank", 32'(blank_out), 32'h0);
        chk("async_rst_sw", 32'(switched), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cur", 32'(cur_src), 32'h0);

        mode = 2'd2;
        sel  = 2'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("blink_seq", 32'(blank_out), 32'(exp_blink[i]));
        end
        @(negedge clk);
        chk("blink_on", 32'(blank_out), 32'h1);
        mode = 2'd0;
        @(negedge clk);
        chk("blink_exit", 32'(blank_out), 32'h0);

        sel = 2'd0;
        repeat (2) @(negedge clk);
        chk("pre_hold", 32'(digits_out), 32'h123);
        mode = 2'd3;
        repeat (2) @(negedge clk);
        src_flat[0 +: DW] = 12'h456;
        repeat (3) @(negedge clk);
        chk("hold_frozen", 32'(digits_out), 32'h123);
        mode = 2'd0;
        @(negedge clk);
        chk("hold_release", 32'(digits_out), 32'h456);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) reset = 1'b1;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) src_flat = 36'({$urandom, $urandom});
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
